mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM stage between the EX/MEM and MEM/WB pipeline registers. Owns the data memory.
//  Performs word/byte loads and stores with sign or zero extension, and models a
//  configurable multi-cycle memory latency. While an access is in flight, stall_out
//  freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB is fed a bubble.
// PARAMETERS
//  DEPTH    256  data memory size in 32-bit words (power of 2); index = addr_in[log2(DEPTH)+1:2]
//  LATENCY  1    cycles per access, legal 1..16; 1 = single-cycle, no stall
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  memRead_in     in   1   load request (from EX/MEM)
//  memWrite_in    in   1   store request (from EX/MEM)
//  asByte_in      in   1   1 = byte access, 0 = word access
//  asUnsigned_in  in   1   byte load: 1 = zero-extend, 0 = sign-extend
//  addr_in        in   32  byte address (ALU result)
//  write_data_in  in   32  store data (rs2 value)
//  read_data_out  out  32  load data, valid in the completion cycle
//  stall_out      out  1   1 = hold upstream pipeline registers; insert bubble into MEM/WB
// BEHAVIOUR
//  - req = memRead_in | memWrite_in. Both set: treated as a store; read_data_out = 0.
//  - FSM states:
//      IDLE: on req with LATENCY>1, load cnt = LATENCY-2 and go to WAIT.
//      WAIT: if cnt != 0, decrement cnt; if cnt == 0, go to IDLE.
//  - stall_out = (IDLE & req & LATENCY>1) | (WAIT & cnt != 0).
//  - Each access therefore stalls for exactly LATENCY-1 cycles.
//  - Completion cycle is the first cycle of the access with stall_out = 0:
//      LATENCY=1: the request cycle itself.
//      otherwise: WAIT with cnt == 0.
//  - Store commits at the clock edge ending the completion cycle; never earlier.
//  - Byte store: write_data_in[7:0] goes to lane addr_in[1:0] (lane 0 = bits 7:0,
//    little-endian). The other lanes are unchanged.
//  - Word store: all 32 bits are written; addr_in[1:0] is ignored.
//  - Load: the array is read asynchronously.
//      Word load: read_data_out = word.
//      Byte load: read_data_out = selected lane, zero- or sign-extended to 32 bits.
//  - read_data_out = 0 except in a load's completion cycle.
//  - Inputs must be held stable by upstream while stall_out = 1. Input changes
//    mid-access are not tracked; the values sampled in the completion cycle are used.
//  - Back-to-back: a new req in the cycle after completion is accepted immediately
//    from IDLE. There are no idle cycles between accesses.
//  - Address wrap: bits above the index range are ignored (modulo DEPTH).
//  - Reset (synchronous):
//      state = IDLE, cnt = 0, stall_out = 0, read_data_out = 0.
//      A pending store is dropped.
//      Memory contents are NOT cleared; they are undefined until written.
//  - Reset asserted together with req: reset wins and the request is discarded.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - Adds output port misaligned_out (1 bit).
//    - It is 1 in the completion cycle of a word access with addr_in[1:0] != 0.
//    - For such an access the store is suppressed and read_data_out = 0.
//    - Reset value 0.
//  MEM_ALIGN_CHECK_EN undefined:
//    - No misaligned_out port.
//    - Word accesses silently use addr_in[1:0] = 0.
// TESTING
//  1. LATENCY=1: word store 0xDEADBEEF @0x10, then load @0x10
//     -> stall_out never 1; read_data_out = 0xDEADBEEF in the load cycle.
//  2. Byte store 0x80 @0x13 over word 0x11223344 @0x10:
//     - signed byte load @0x13 -> 0xFFFFFF80
//     - unsigned byte load @0x13 -> 0x00000080
//     - word load @0x10 -> 0x80223344
//  3. LATENCY=4: load request
//     -> stall_out = 1 for exactly 3 cycles, data valid in cycle 4.
//     A store whose memory is sampled before its completion edge shows the old value.
//  4. LATENCY=3: store, then immediately a load of the same address after completion
//     -> load returns the new data; total 6 cycles; stall pattern 1,1,0,1,1,0.
//  5. LATENCY=4: assert reset in cycle 2 of a store
//     -> stall_out = 0 next cycle; memory word unchanged; next request takes a full 4 cycles.
//  6. MEM_ALIGN_CHECK_EN: word store @0x22
//     -> misaligned_out = 1 in the completion cycle; words @0x20 and @0x24 unchanged.
//     Without the macro: the word is written to @0x20.

Source files
------------

// File: rtl/mem_access_if.sv
// Request/response bundle between the EX/MEM register and the MEM stage.
// MEM_ALIGN_CHECK_EN adds the misaligned_out response signal.
interface mem_access_if;
    logic        memRead_in;
    logic        memWrite_in;
    logic        asByte_in;
    logic        asUnsigned_in;
    logic [31:0] addr_in;
    logic [31:0] write_data_in;
    logic [31:0] read_data_out;
    logic        stall_out;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned_out;

    modport master (
        output memRead_in, memWrite_in, asByte_in, asUnsigned_in, addr_in, write_data_in,
        input  read_data_out, stall_out, misaligned_out
    );
    modport slave (
        input  memRead_in, memWrite_in, asByte_in, asUnsigned_in, addr_in, write_data_in,
        output read_data_out, stall_out, misaligned_out
    );
`else
    modport master (
        output memRead_in, memWrite_in, asByte_in, asUnsigned_in, addr_in, write_data_in,
        input  read_data_out, stall_out
    );
    modport slave (
        input  memRead_in, memWrite_in, asByte_in, asUnsigned_in, addr_in, write_data_in,
        output read_data_out, stall_out
    );
`endif
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data memory with byte/word access and configurable latency.
// Optional MEM_ALIGN_CHECK_EN flags and suppresses misaligned word accesses.
module mem_access_stage #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  mem_io
);
    localparam int unsigned IdxW       = $clog2(DEPTH);
    localparam bit          MultiCycle = (LATENCY > 1);
    localparam logic [3:0]  CntInit    = MultiCycle ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            req, stall, complete, misaligned, store_en;
    logic [IdxW-1:0] idx;
    logic [1:0]      lane;
    logic [31:0]     word, lane_ext, load_data;
    logic [7:0]      lane_byte;
    logic [31:0]     mem_q [DEPTH];
    logic            unused_addr_bits;

    assign req              = mem_io.memRead_in | mem_io.memWrite_in;
    assign idx              = mem_io.addr_in[IdxW+1:2];
    assign lane             = mem_io.addr_in[1:0];
    assign unused_addr_bits = ^mem_io.addr_in[31:IdxW+2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (MultiCycle) begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                        stall   = 1'b1;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    stall = 1'b1;
                end else begin
                    state_d  = StIdle;
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned            = complete & ~reset & ~mem_io.asByte_in & (lane != 2'b00);
    assign mem_io.misaligned_out = misaligned;
`else
    assign misaligned = 1'b0;
`endif

    // Reset wins over a coincident request, so every side effect is gated by it.
    assign store_en = complete & ~reset & mem_io.memWrite_in & ~misaligned;

    always_ff @(posedge clk) begin
        if (store_en) begin
            if (mem_io.asByte_in) begin
                mem_q[idx][{lane, 3'b000} +: 8] <= mem_io.write_data_in[7:0];
            end else begin
                mem_q[idx] <= mem_io.write_data_in;
            end
        end
    end

    assign word      = mem_q[idx];
    assign lane_byte = word[{lane, 3'b000} +: 8];
    assign lane_ext  = {{24{~mem_io.asUnsigned_in & lane_byte[7]}}, lane_byte};
    assign load_data = mem_io.asByte_in ? lane_ext : word;

    assign mem_io.stall_out     = stall & ~reset;
    assign mem_io.read_data_out = (complete & ~reset & mem_io.memRead_in & ~mem_io.memWrite_in
                                   & ~misaligned) ? load_data : 32'd0;
endmodule
